mips_decode_pipe: RTL and testbench
===================================

Name: mips_decode_pipe

Overview:
Registered, buffered successor to the combinational MIPS arithmetic decoder. Accepts full 32-bit instructions over a valid/ready handshake and decodes the same arithmetic subset. Adds register-specifier extraction, immediate extension, destination selection and exception accounting. Results are held in a parametrised FIFO so fetch and execute stall independently.

Parameters:
DEPTH, 2, FIFO entries of decoded results; power of two, 2..16.
EXC_CNT_W, 8, width of the saturating exception counter.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  insn is presented
in_ready  out  1  FIFO can accept (not full)
insn  in  32  MIPS instruction word
flush  in  1  discard all buffered entries
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer takes head this cycle
out_rs  out  5  insn[25:21]
out_rt  out  5  insn[20:16]
out_wreg  out  5  destination: rt if I-type, else rd (insn[15:11])
out_imm  out  32  extended immediate
out_alu_src2  out  2  00 register, 01 sign-extended imm, 10 zero-extended imm
out_alu_op  out  3  ALU control
out_writeenable  out  1  register file write
out_except  out  1  unrecognised opcode/funct
occupancy  out  $clog2(DEPTH+1)  entries held
exc_count  out  EXC_CNT_W  saturating count of excepting instructions accepted
exc_sticky  out  1  set when any excepting instruction is accepted
exc_clear  in  1  clears exc_sticky and exc_count

Behaviour:
- Decode table, with opcode = insn[31:26] and funct = insn[5:0]:
  - opcode 0x00 with funct 0x20 add -> alu_op 010.
  - opcode 0x00 with funct 0x22 sub -> 011.
  - opcode 0x00 with funct 0x24 and -> 100.
  - opcode 0x00 with funct 0x25 or -> 101.
  - opcode 0x00 with funct 0x27 nor -> 110.
  - opcode 0x00 with funct 0x26 xor -> 111.
  - addi 0x08 -> 010, src2 01.
  - andi 0x0c -> 100, src2 10.
  - ori 0x0d -> 101, src2 10.
  - xori 0x0e -> 111, src2 10.
  - R-type: src2 00, wreg = rd. I-type: wreg = rt.
- out_imm: src2=01 gives sign-extended insn[15:0]; every other case gives zero-extended insn[15:0].
- writeenable = recognised AND wreg != 0. Writes to $0 are suppressed; this is new behaviour.
- Unrecognised instruction: except=1, writeenable=0, alu_op=000, src2=00. rs/rt/wreg/imm still carry raw fields. Entry is still enqueued.
- Decoding is combinational on insn. The decoded bundle is written into the FIFO tail on push = in_valid & in_ready.
- Latency: an instruction accepted in cycle N is visible at the head (out_valid=1) in cycle N+1 if the FIFO was empty.
- Head outputs are driven from the storage at the read pointer. Pop = out_valid & out_ready.
- in_ready = (occupancy != DEPTH). A push while full is impossible by construction.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. Legal when full only if in_ready was already high; it is not.
- Pointers wrap modulo DEPTH. Occupancy tracks 0..DEPTH exactly.
- flush: occupancy -> 0, pointers -> 0, and any same-cycle push is dropped. out_valid=0 the next cycle. A dropped push does not touch exc_count or exc_sticky.
- Exception accounting happens on push of an excepting entry:
  - exc_count increments and saturates at 2^EXC_CNT_W-1.
  - exc_sticky -> 1.
- exc_clear: exc_count -> 0 and exc_sticky -> 0.
  - Same cycle as an excepting push: exc_count -> 1 and exc_sticky -> 1 (the new event wins).
- Reset (synchronous, mid-operation included):
  - Pointers and occupancy -> 0.
  - out_valid=0, in_ready=1.
  - exc_count=0, exc_sticky=0.
  - Head data outputs are 0 while the FIFO is empty; stored data is don't-care after reset.
- Reset has priority over flush, push, pop and exc_clear.

Test Plan:
- add $3,$1,$2: push 0x00221820, out_ready=1 -> next cycle out_valid=1, rs=1, rt=2, wreg=3, alu_op=010, src2=00, writeenable=1, except=0; following cycle out_valid=0.
- addi $5,$4,-1 (0x2085FFFF) and andi $6,$7,0x8000 (0x30E68000) back-to-back -> first entry: imm=0xFFFFFFFF, src2=01, op=010, wreg=5. Second entry: imm=0x00008000, src2=10, op=100, wreg=6.
- Illegal 0x00221821 (funct 0x21) -> except=1, writeenable=0, alu_op=000. exc_count=1 and exc_sticky=1 the cycle after the push.
- DEPTH=2, out_ready=0, push three instructions -> in_ready=0 after two pushes, occupancy=2, third held off. Then out_ready=1 with continuous in_valid -> one pop and one push per cycle in original order, occupancy stays 2.
- Fill 2 entries, assert flush together with an illegal push -> occupancy=0, out_valid=0, exc_count unchanged. Separately, exc_clear together with an illegal push -> exc_count=1, exc_sticky=1. Saturation: 300 illegal pushes with EXC_CNT_W=8 -> exc_count=255.
- Write to $0: add $0,$1,$2 (0x00220020) -> except=0, writeenable=0. Then assert reset while 2 entries are held -> next cycle occupancy=0, out_valid=0, in_ready=1, exc_count=0.

Source files
------------

// File: rtl/mips_decode_pipe_if.sv
// Fetch/execute-side signals of the buffered MIPS arithmetic decoder.
interface mips_decode_pipe_if #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned EXC_CNT_W = 8
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          insn;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_rs;
    logic [4:0]           out_rt;
    logic [4:0]           out_wreg;
    logic [31:0]          out_imm;
    logic [1:0]           out_alu_src2;
    logic [2:0]           out_alu_op;
    logic                 out_writeenable;
    logic                 out_except;
    logic [OCC_W-1:0]     occupancy;
    logic [EXC_CNT_W-1:0] exc_count;
    logic                 exc_sticky;
    logic                 exc_clear;

    modport slave (
        input  in_valid, insn, flush, out_ready, exc_clear,
        output in_ready, out_valid, out_rs, out_rt, out_wreg, out_imm,
               out_alu_src2, out_alu_op, out_writeenable, out_except,
               occupancy, exc_count, exc_sticky
    );

    modport master (
        output in_valid, insn, flush, out_ready, exc_clear,
        input  in_ready, out_valid, out_rs, out_rt, out_wreg, out_imm,
               out_alu_src2, out_alu_op, out_writeenable, out_except,
               occupancy, exc_count, exc_sticky
    );
endinterface

// File: rtl/mips_decode_pipe.sv
// MIPS arithmetic-subset decoder feeding a DEPTH-entry result FIFO,
// with saturating exception accounting on accepted illegal instructions.
module mips_decode_pipe #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned EXC_CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    mips_decode_pipe_if.slave  bus
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [31:0] imm;
        logic [1:0]  alu_src2;
        logic [2:0]  alu_op;
        logic        writeenable;
        logic        except;
    } entry_t;

    entry_t               mem [DEPTH];
    entry_t               dec_c;
    entry_t               head_c;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic [EXC_CNT_W-1:0] exc_cnt;
    logic                 exc_stk;
    logic                 push_c;
    logic                 pop_c;
    logic                 exc_push_c;
    logic                 recog_c;
    logic                 i_fmt_c;

    wire [5:0] opcode = bus.insn[31:26];
    wire [5:0] funct  = bus.insn[5:0];

    // Decode; non-zero opcodes take their destination from rt.
    always_comb begin
        recog_c        = 1'b0;
        dec_c          = '0;
        dec_c.rs       = bus.insn[25:21];
        dec_c.rt       = bus.insn[20:16];
        i_fmt_c        = (opcode != 6'h00);
        if (opcode == 6'h00) begin
            recog_c = 1'b1;
            case (funct)
                6'h20:   dec_c.alu_op = 3'b010;
                6'h22:   dec_c.alu_op = 3'b011;
                6'h24:   dec_c.alu_op = 3'b100;
                6'h25:   dec_c.alu_op = 3'b101;
                6'h27:   dec_c.alu_op = 3'b110;
                6'h26:   dec_c.alu_op = 3'b111;
                default: recog_c = 1'b0;
            endcase
        end else begin
            recog_c = 1'b1;
            case (opcode)
                6'h08:   begin dec_c.alu_op = 3'b010; dec_c.alu_src2 = 2'b01; end
                6'h0c:   begin dec_c.alu_op = 3'b100; dec_c.alu_src2 = 2'b10; end
                6'h0d:   begin dec_c.alu_op = 3'b101; dec_c.alu_src2 = 2'b10; end
                6'h0e:   begin dec_c.alu_op = 3'b111; dec_c.alu_src2 = 2'b10; end
                default: recog_c = 1'b0;
            endcase
        end
        dec_c.wreg        = i_fmt_c ? bus.insn[20:16] : bus.insn[15:11];
        dec_c.imm         = (dec_c.alu_src2 == 2'b01)
                          ? {{16{bus.insn[15]}}, bus.insn[15:0]}
                          : {16'h0000, bus.insn[15:0]};
        dec_c.writeenable = recog_c && (dec_c.wreg != 5'd0);
        dec_c.except      = !recog_c;
    end

    assign push_c     = bus.in_valid && bus.in_ready;
    assign pop_c      = bus.out_valid && bus.out_ready;
    assign exc_push_c = push_c && !bus.flush && dec_c.except;

    // Pointers and occupancy; flush discards contents and any same-cycle push.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      occ <= occ + OCC_W'(1);
            else if (!push_c && pop_c) occ <= occ - OCC_W'(1);
        end
    end

    // Payload storage needs no reset; empty-FIFO outputs are masked below.
    always_ff @(posedge clock) begin
        if (push_c && !bus.flush && !reset) mem[wr_ptr] <= dec_c;
    end

    // Exception accounting; a new event in the clearing cycle survives it.
    always_ff @(posedge clock) begin
        if (reset) begin
            exc_cnt <= '0;
            exc_stk <= 1'b0;
        end else if (bus.exc_clear) begin
            exc_cnt <= exc_push_c ? EXC_CNT_W'(1) : '0;
            exc_stk <= exc_push_c;
        end else if (exc_push_c) begin
            if (exc_cnt != '1) exc_cnt <= exc_cnt + EXC_CNT_W'(1);
            exc_stk <= 1'b1;
        end
    end

    assign head_c = (occ != '0) ? mem[rd_ptr] : '0;

    assign bus.in_ready        = (occ != OCC_W'(DEPTH));
    assign bus.out_valid       = (occ != '0);
    assign bus.out_rs          = head_c.rs;
    assign bus.out_rt          = head_c.rt;
    assign bus.out_wreg        = head_c.wreg;
    assign bus.out_imm         = head_c.imm;
    assign bus.out_alu_src2    = head_c.alu_src2;
    assign bus.out_alu_op      = head_c.alu_op;
    assign bus.out_writeenable = head_c.writeenable;
    assign bus.out_except      = head_c.except;
    assign bus.occupancy       = occ;
    assign bus.exc_count       = exc_cnt;
    assign bus.exc_sticky      = exc_stk;
endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed bench for mips_decode_pipe: decode table, FIFO flow, flush,
// exception accounting and reset.
module tb_mips_decode_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_decode_pipe_if #(.DEPTH(2), .EXC_CNT_W(8)) bus ();

    mips_decode_pipe #(.DEPTH(2), .EXC_CNT_W(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ILLEGAL = 32'h0022_1821;
    localparam logic [31:0] ADD3    = 32'h0022_1820;

    logic [31:0] tab_insn [7] = '{32'h0022_3822, 32'h0022_3824, 32'h0022_3825,
                                  32'h0022_3827, 32'h0022_3826, 32'h3441_8001,
                                  32'h3841_8001};
    logic [2:0]  tab_op   [7] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5, 3'd7};
    logic [1:0]  tab_src  [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    logic [4:0]  tab_wreg [7] = '{5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd1, 5'd1};
    logic [31:0] tab_imm  [7] = '{32'h3822, 32'h3824, 32'h3825, 32'h3827,
                                  32'h3826, 32'h8001, 32'h8001};
    logic [31:0] seq [4] = '{32'h0022_1820, 32'h0022_2020, 32'h0022_2820, 32'h0022_3020};

    initial begin
        bus.in_valid  = 1'b0;
        bus.insn      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.exc_clear = 1'b0;

        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check("rst_occ",    32'(bus.occupancy),  0);
        check("rst_ovalid", 32'(bus.out_valid),  0);
        check("rst_iready", 32'(bus.in_ready),   1);
        check("rst_exccnt", 32'(bus.exc_count),  0);
        check("rst_imm",    bus.out_imm,         0);

        // add $3,$1,$2 passes straight through
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.insn = ADD3; tick(); bus.in_valid = 1'b0;
        check("add_valid", 32'(bus.out_valid),       1);
        check("add_rs",    32'(bus.out_rs),          1);
        check("add_rt",    32'(bus.out_rt),          2);
        check("add_wreg",  32'(bus.out_wreg),        3);
        check("add_op",    32'(bus.out_alu_op),      2);
        check("add_src2",  32'(bus.out_alu_src2),    0);
        check("add_we",    32'(bus.out_writeenable), 1);
        check("add_exc",   32'(bus.out_except),      0);
        tick();
        check("add_drain", 32'(bus.out_valid),       0);

        // addi / andi back-to-back, held then drained
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.insn = 32'h2085_FFFF; tick();
        bus.insn = 32'h30E6_8000; tick(); bus.in_valid = 1'b0;
        check("addi_imm",  bus.out_imm,             32'hFFFF_FFFF);
        check("addi_src2", 32'(bus.out_alu_src2),   1);
        check("addi_op",   32'(bus.out_alu_op),     2);
        check("addi_wreg", 32'(bus.out_wreg),       5);
        check("full_occ",  32'(bus.occupancy),      2);
        check("full_rdy",  32'(bus.in_ready),       0);
        bus.out_ready = 1'b1; tick();
        check("andi_imm",  bus.out_imm,             32'h0000_8000);
        check("andi_src2", 32'(bus.out_alu_src2),   2);
        check("andi_op",   32'(bus.out_alu_op),     4);
        check("andi_wreg", 32'(bus.out_wreg),       6);
        check("andi_occ",  32'(bus.occupancy),      1);
        tick();
        check("ai_empty",  32'(bus.occupancy),      0);

        // remaining decode table entries, one at a time
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1; bus.insn = tab_insn[i]; tick(); bus.in_valid = 1'b0;
            check($sformatf("tab%0d_op", i),   32'(bus.out_alu_op),   32'(tab_op[i]));
            check($sformatf("tab%0d_src", i),  32'(bus.out_alu_src2), 32'(tab_src[i]));
            check($sformatf("tab%0d_wreg", i), 32'(bus.out_wreg),     32'(tab_wreg[i]));
            check($sformatf("tab%0d_imm", i),  bus.out_imm,           tab_imm[i]);
            check($sformatf("tab%0d_exc", i),  32'(bus.out_except),   0);
            tick();
        end

        // illegal funct 0x21
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.insn = ILLEGAL; tick(); bus.in_valid = 1'b0;
        check("ill_exc",    32'(bus.out_except),      1);
        check("ill_we",     32'(bus.out_writeenable), 0);
        check("ill_op",     32'(bus.out_alu_op),      0);
        check("ill_rs",     32'(bus.out_rs),          1);
        check("ill_imm",    bus.out_imm,              32'h0000_1821);
        check("ill_cnt",    32'(bus.exc_count),       1);
        check("ill_sticky", 32'(bus.exc_sticky),      1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

        // backpressure and ordering
        bus.in_valid = 1'b1; bus.insn = seq[0]; tick();
        bus.insn = seq[1]; tick();
        check("bp_occ2",  32'(bus.occupancy), 2);
        check("bp_rdy0",  32'(bus.in_ready),  0);
        bus.insn = seq[2]; tick();
        check("bp_held",  32'(bus.occupancy), 2);
        check("bp_head0", 32'(bus.out_wreg),  3);
        bus.out_ready = 1'b1; tick();
        check("bp_head1", 32'(bus.out_wreg),  4);
        check("bp_occ_a", 32'(bus.occupancy), 1);
        tick();
        check("bp_head2", 32'(bus.out_wreg),  5);
        check("bp_occ_b", 32'(bus.occupancy), 1);
        bus.insn = seq[3]; tick(); bus.in_valid = 1'b0;
        check("bp_head3", 32'(bus.out_wreg),  6);
        check("bp_occ_c", 32'(bus.occupancy), 1);
        tick(); bus.out_ready = 1'b0;
        check("bp_empty", 32'(bus.occupancy), 0);

        // flush drops contents and a same-cycle illegal push
        bus.in_valid = 1'b1; bus.insn = seq[0]; tick(); bus.insn = seq[1]; tick();
        bus.flush = 1'b1; bus.insn = ILLEGAL; tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("fl_occ",    32'(bus.occupancy), 0);
        check("fl_valid",  32'(bus.out_valid), 0);
        check("fl_cnt",    32'(bus.exc_count), 1);

        // clear coinciding with an illegal push keeps the new event
        bus.in_valid = 1'b1; bus.exc_clear = 1'b1; bus.insn = ILLEGAL; tick();
        bus.in_valid = 1'b0; bus.exc_clear = 1'b0;
        check("clr_cnt",    32'(bus.exc_count),  1);
        check("clr_sticky", 32'(bus.exc_sticky), 1);
        bus.exc_clear = 1'b1; bus.out_ready = 1'b1; tick(); bus.exc_clear = 1'b0;
        check("clr0_cnt",    32'(bus.exc_count),  0);
        check("clr0_sticky", 32'(bus.exc_sticky), 0);

        // saturation
        bus.in_valid = 1'b1; bus.insn = ILLEGAL;
        for (int i = 0; i < 300; i++) tick();
        bus.in_valid = 1'b0; tick(); bus.out_ready = 1'b0;
        check("sat_cnt", 32'(bus.exc_count), 255);

        // write to $0 is suppressed
        bus.in_valid = 1'b1; bus.insn = 32'h0022_0020; tick();
        check("r0_exc",  32'(bus.out_except),      0);
        check("r0_we",   32'(bus.out_writeenable), 0);
        check("r0_wreg", 32'(bus.out_wreg),        0);
        bus.insn = ADD3; tick(); bus.in_valid = 1'b0;
        check("r0_occ",  32'(bus.occupancy),       2);

        // mid-operation reset
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_occ",    32'(bus.occupancy),  0);
        check("mrst_valid",  32'(bus.out_valid),  0);
        check("mrst_rdy",    32'(bus.in_ready),   1);
        check("mrst_cnt",    32'(bus.exc_count),  0);
        check("mrst_sticky", 32'(bus.exc_sticky), 0);
        check("mrst_imm",    bus.out_imm,         0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
